exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle fetch/decode/execute sequencer for the 8-bit accumulator processor. It sits directly upstream of the ALU: it fetches 12-bit instructions from program ROM, owns the accumulator, carry flag, PC and a 16x8 register file, and drives the ALU operand/opcode inputs. It latches the ALU result and carry back into the accumulator and flag. Every instruction takes exactly 3 cycles; an instruction may be a branch or a halt.

## Interface
Parameters:
- none; widths are fixed (8-bit data, 8-bit PC, 12-bit instruction, 16 registers)

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  1 = sequencer may start a new fetch; 0 = stall in FETCH
- prog_addr  out  8  program ROM address (= PC)
- prog_data  in  12  ROM word; synchronous ROM, valid one cycle after prog_addr
- alu_code  out  3  ALU operation, encoded with the shared ALU_* macros
- alu_a  out  8  ALU operand A (= accumulator)
- alu_b  out  8  ALU operand B (register value or immediate)
- alu_ci  out  1  ALU carry-in
- alu_out  in  8  ALU result
- alu_co  in  1  ALU carry/borrow out
- accu  out  8  accumulator
- carry  out  1  carry flag
- halted  out  1  1 after HLT has executed

## Operation
- Instruction word: ir[11:8] opcode, ir[7:0] operand; register ops use ir[3:0] as register index r, and ir[7:4] is ignored.
- Opcodes:
  - 0 NOP
  - 1 ADD r: ALU_ADD, ci=0
  - 2 ADC r: ALU_ADD, ci=C
  - 3 SUB r: ALU_SUB, ci=0
  - 4 SBC r: ALU_SUB, ci=C
  - 5 AND r
  - 6 OR r
  - 7 XOR r
  - 8 NOT
  - 9 LD r: ALU_LD, b=R[r]
  - A LDI imm: ALU_LD, b=imm
  - B ST r: R[r]<=A
  - C JMP a
  - D JZ a: taken if A==0
  - E JC a: taken if C==1
  - F HLT
- ALU ops (1-A): at the end of EXEC, accu<=alu_out and carry<=alu_co. AND/OR/XOR/NOT/LD/LDI therefore clear C.
- SUB semantics are those of the ALU: 9-bit {Co,Out}=A-B-Ci; Co=1 means borrow.
- ST, jumps, NOP and HLT leave accu and carry unchanged.
- ALU drive for ALU ops:
  - alu_a=accu.
  - alu_b=R[ir[3:0]], or ir[7:0] for LDI.
  - alu_code and alu_ci are decoded combinationally from ir in every state; only EXEC latches the result.
- ALU drive for non-ALU opcodes: alu_code=ALU_ADD, alu_b=0, alu_ci=0.
- Taken jump: pc<=ir[7:0] in EXEC. Not-taken jump: pc keeps its incremented value.
- FSM states:
  - FETCH: prog_addr=pc. If run=1, go to DECODE; else stay.
  - DECODE: ir<=prog_data; pc<=pc+1 (wraps 0xFF->0x00); go to EXEC.
  - EXEC: perform op. Next state is HALT if opcode F, else FETCH.
  - HALT: halted=1. Left only by reset; run is ignored.
- The register file is 16x8 and is written only by ST. It is readable in the same cycle, and ST to r followed by LD r returns the new value.
- run is sampled only in FETCH. Deasserting it during DECODE/EXEC does not abort the instruction in flight.

## Timing
- Reset (async assert, any state, mid-instruction included): state=FETCH, pc=0, ir=0 (NOP), accu=0, carry=0, halted=0, all R[i]=0, prog_addr=0. alu_code=ALU_ADD, alu_b=0, alu_ci=0.
- Release of rst_n is synchronous to clk. First FETCH is in the first rising edge after release with run=1.
- Latency: 3 cycles per instruction with run held high. accu/carry/pc/R updates are visible in the cycle after EXEC.
- Throughput: one instruction per 3 cycles. No pipelining, so there are no hazards.
- halted asserts in the cycle after the HLT EXEC and stays high; prog_addr freezes at HLT address+1.

## Test plan
- Reset mid-EXEC of ADD -> all outputs at reset values immediately (async). After release with run=1: prog_addr=0 then 1 on consecutive fetches.
- LDI 0xFF; ST 1; LDI 0x01; ADD 1 -> accu=0x00, carry=1. Then JZ 0x20 is taken (prog_addr=0x20). Then JC 0x30 is taken.
- LDI 0x07; ST 2; LDI 0x05; SUB 2 -> accu=0xFE, carry=1. Then SBC 2 -> accu=0xF6, carry=0.
- LDI 0x3C; ST 0; LDI 0xA5; AND 0 / OR 0 / XOR 0 / NOT -> 0x24, 0x3C, 0x00, 0xFF; carry=0 after each.
- run=0 held 10 cycles in FETCH -> prog_addr, accu and pc stable. Toggling run during DECODE does not stop the instruction completing.
- Program at 0xFE: NOP; NOP -> prog_addr wraps to 0x00. HLT -> halted=1, and prog_addr is frozen for 20 cycles regardless of run.

Source files
------------

// File: rtl/exec_sequencer.sv
// Three-cycle fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Owns PC, IR, accumulator, carry flag and a 16x8 register file; drives the external ALU.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_LD  3'd6
`endif

module exec_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic [7:0]  prog_addr,
  input  logic [11:0] prog_data,
  output logic [2:0]  alu_code,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic        alu_ci,
  input  logic [7:0]  alu_out,
  input  logic        alu_co,
  output logic [7:0]  accu,
  output logic        carry,
  output logic        halted
);

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

  state_t      state_r;
  logic [7:0]  pc_r;
  logic [11:0] ir_r;
  logic [7:0]  accu_r;
  logic        carry_r;
  logic        halted_r;
  logic [7:0]  regs_r [16];

  logic [3:0]  opc_s;
  logic [3:0]  ridx_s;
  logic [7:0]  rval_s;
  logic        is_alu_s;
  logic        taken_s;

  assign opc_s  = ir_r[11:8];
  assign ridx_s = ir_r[3:0];
  assign rval_s = regs_r[ridx_s];

  // Combinational opcode decode: ALU drive and branch condition from the current IR.
  always_comb begin
    alu_code = `ALU_ADD;
    alu_b    = 8'h00;
    alu_ci   = 1'b0;
    is_alu_s = 1'b1;
    taken_s  = 1'b0;
    case (opc_s)
      4'h1: alu_b = rval_s;
      4'h2: begin
        alu_b  = rval_s;
        alu_ci = carry_r;
      end
      4'h3: begin
        alu_code = `ALU_SUB;
        alu_b    = rval_s;
      end
      4'h4: begin
        alu_code = `ALU_SUB;
        alu_b    = rval_s;
        alu_ci   = carry_r;
      end
      4'h5: begin
        alu_code = `ALU_AND;
        alu_b    = rval_s;
      end
      4'h6: begin
        alu_code = `ALU_OR;
        alu_b    = rval_s;
      end
      4'h7: begin
        alu_code = `ALU_XOR;
        alu_b    = rval_s;
      end
      4'h8: begin
        alu_code = `ALU_NOT;
        alu_b    = rval_s;
      end
      4'h9: begin
        alu_code = `ALU_LD;
        alu_b    = rval_s;
      end
      4'hA: begin
        alu_code = `ALU_LD;
        alu_b    = ir_r[7:0];
      end
      4'hC: begin
        is_alu_s = 1'b0;
        taken_s  = 1'b1;
      end
      4'hD: begin
        is_alu_s = 1'b0;
        taken_s  = (accu_r == 8'h00);
      end
      4'hE: begin
        is_alu_s = 1'b0;
        taken_s  = carry_r;
      end
      default: is_alu_s = 1'b0;
    endcase
  end

  // Sequencer FSM with architectural state updates at the end of EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_FETCH;
      pc_r     <= 8'h00;
      ir_r     <= 12'h000;
      accu_r   <= 8'h00;
      carry_r  <= 1'b0;
      halted_r <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      case (state_r)
        ST_FETCH: begin
          if (run) begin
            state_r <= ST_DECODE;
          end else begin
            state_r <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          ir_r    <= prog_data;
          pc_r    <= pc_r + 8'd1;
          state_r <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_alu_s) begin
            accu_r  <= alu_out;
            carry_r <= alu_co;
          end
          if (opc_s == 4'hB) begin
            regs_r[ridx_s] <= accu_r;
          end
          if (taken_s) begin
            pc_r <= ir_r[7:0];
          end
          if (opc_s == 4'hF) begin
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
          end else begin
            state_r  <= ST_FETCH;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: state_r <= ST_FETCH;
      endcase
    end
  end

  assign prog_addr = pc_r;
  assign alu_a     = accu_r;
  assign accu      = accu_r;
  assign carry     = carry_r;
  assign halted    = halted_r;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed program table, multi-cycle corner cases,
// and random programs checked against an instruction-level reference model.
`ifndef ALU_ADD
`define ALU_ADD 3'd0
`define ALU_SUB 3'd1
`define ALU_AND 3'd2
`define ALU_OR  3'd3
`define ALU_XOR 3'd4
`define ALU_NOT 3'd5
`define ALU_LD  3'd6
`endif

module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic [7:0]  prog_addr;
  logic [11:0] prog_data = 12'h000;
  logic [2:0]  alu_code;
  logic [7:0]  alu_a, alu_b, alu_out;
  logic        alu_ci, alu_co;
  logic [7:0]  accu;
  logic        carry, halted;

  exec_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .alu_code(alu_code), .alu_a(alu_a), .alu_b(alu_b), .alu_ci(alu_ci),
    .alu_out(alu_out), .alu_co(alu_co),
    .accu(accu), .carry(carry), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [11:0] rom [256];
  always @(posedge clk) prog_data <= rom[prog_addr];

  // Environment ALU
  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = 9'h000;
    case (alu_code)
      `ALU_ADD: alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_ci};
      `ALU_SUB: alu_sum = {1'b0, alu_a} - {1'b0, alu_b} - {8'h00, alu_ci};
      `ALU_AND: alu_sum = {1'b0, alu_a & alu_b};
      `ALU_OR:  alu_sum = {1'b0, alu_a | alu_b};
      `ALU_XOR: alu_sum = {1'b0, alu_a ^ alu_b};
      `ALU_NOT: alu_sum = {1'b0, ~alu_a};
      `ALU_LD:  alu_sum = {1'b0, alu_b};
      default:  alu_sum = 9'h000;
    endcase
  end
  assign alu_out = alu_sum[7:0];
  assign alu_co  = alu_sum[8];

  int chk_cnt = 0;
  int pass_cnt = 0;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%02h expected 0x%02h", nm, act, exp);
  endtask

  // Instruction-level reference model
  logic [7:0] m_pc, m_a;
  logic       m_c, m_h;
  logic [7:0] m_r [16];

  task automatic model_reset();
    m_pc = 8'h00; m_a = 8'h00; m_c = 1'b0; m_h = 1'b0;
    for (int i = 0; i < 16; i++) m_r[i] = 8'h00;
  endtask

  task automatic ref_step();
    logic [11:0] w;
    logic [7:0]  rv;
    int s;
    w  = rom[m_pc];
    rv = m_r[w[3:0]];
    m_pc = m_pc + 8'd1;
    case (w[11:8])
      4'h1, 4'h2: begin
        s = int'(m_a) + int'(rv) + ((w[11:8] == 4'h2) ? int'(m_c) : 0);
        m_a = s[7:0]; m_c = (s > 255);
      end
      4'h3, 4'h4: begin
        s = int'(m_a) - int'(rv) - ((w[11:8] == 4'h4) ? int'(m_c) : 0);
        m_a = s[7:0]; m_c = (s < 0);
      end
      4'h5: begin m_a = m_a & rv; m_c = 1'b0; end
      4'h6: begin m_a = m_a | rv; m_c = 1'b0; end
      4'h7: begin m_a = m_a ^ rv; m_c = 1'b0; end
      4'h8: begin m_a = ~m_a;     m_c = 1'b0; end
      4'h9: begin m_a = rv;       m_c = 1'b0; end
      4'hA: begin m_a = w[7:0];   m_c = 1'b0; end
      4'hB: m_r[w[3:0]] = m_a;
      4'hC: m_pc = w[7:0];
      4'hD: if (m_a == 8'h00) m_pc = w[7:0];
      4'hE: if (m_c) m_pc = w[7:0];
      4'hF: m_h = 1'b1;
      default: ;
    endcase
  endtask

  task automatic step_and_check(input string tag);
    ref_step();
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_pc"}, prog_addr, m_pc);
    check({tag, "_accu"}, accu, m_a);
    check({tag, "_carry"}, {7'd0, carry}, {7'd0, m_c});
    check({tag, "_halted"}, {7'd0, halted}, {7'd0, m_h});
  endtask

  task automatic do_reset();
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] instr;
    logic [7:0]  acc;
    logic        cy;
    logic [7:0]  npc;
  } vec_t;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vec_t tbl[$];
    logic [3:0] op;
    int k;

    tbl.push_back('{8'h00, 12'hAFF, 8'hFF, 1'b0, 8'h01});
    tbl.push_back('{8'h01, 12'hB01, 8'hFF, 1'b0, 8'h02});
    tbl.push_back('{8'h02, 12'hA01, 8'h01, 1'b0, 8'h03});
    tbl.push_back('{8'h03, 12'h101, 8'h00, 1'b1, 8'h04});
    tbl.push_back('{8'h04, 12'hD20, 8'h00, 1'b1, 8'h20});
    tbl.push_back('{8'h20, 12'hE30, 8'h00, 1'b1, 8'h30});
    tbl.push_back('{8'h30, 12'hA07, 8'h07, 1'b0, 8'h31});
    tbl.push_back('{8'h31, 12'hB02, 8'h07, 1'b0, 8'h32});
    tbl.push_back('{8'h32, 12'hA05, 8'h05, 1'b0, 8'h33});
    tbl.push_back('{8'h33, 12'h302, 8'hFE, 1'b1, 8'h34});
    tbl.push_back('{8'h34, 12'h402, 8'hF6, 1'b0, 8'h35});
    tbl.push_back('{8'h35, 12'hA3C, 8'h3C, 1'b0, 8'h36});
    tbl.push_back('{8'h36, 12'hB00, 8'h3C, 1'b0, 8'h37});
    tbl.push_back('{8'h37, 12'hAA5, 8'hA5, 1'b0, 8'h38});
    tbl.push_back('{8'h38, 12'h500, 8'h24, 1'b0, 8'h39});
    tbl.push_back('{8'h39, 12'h600, 8'h3C, 1'b0, 8'h3A});
    tbl.push_back('{8'h3A, 12'h700, 8'h00, 1'b0, 8'h3B});
    tbl.push_back('{8'h3B, 12'h800, 8'hFF, 1'b0, 8'h3C});
    tbl.push_back('{8'h3C, 12'hD50, 8'hFF, 1'b0, 8'h3D});
    tbl.push_back('{8'h3D, 12'hE50, 8'hFF, 1'b0, 8'h3E});
    tbl.push_back('{8'h3E, 12'h900, 8'h3C, 1'b0, 8'h3F});
    tbl.push_back('{8'h3F, 12'h000, 8'h3C, 1'b0, 8'h40});
    tbl.push_back('{8'h40, 12'hC80, 8'h3C, 1'b0, 8'h80});
    tbl.push_back('{8'h80, 12'hB03, 8'h3C, 1'b0, 8'h81});
    tbl.push_back('{8'h81, 12'h9F3, 8'h3C, 1'b0, 8'h82});
    tbl.push_back('{8'h82, 12'hAFF, 8'hFF, 1'b0, 8'h83});
    tbl.push_back('{8'h83, 12'h100, 8'h3B, 1'b1, 8'h84});
    tbl.push_back('{8'h84, 12'h200, 8'h78, 1'b0, 8'h85});

    for (int a = 0; a < 256; a++) rom[a] = 12'h000;
    foreach (tbl[i]) rom[tbl[i].addr] = tbl[i].instr;
    rom[8'h85] = 12'h100;

    // Directed program table
    do_reset();
    run = 1'b1;
    foreach (tbl[i]) begin
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("tbl%0d_pc", i), prog_addr, tbl[i].npc);
      check($sformatf("tbl%0d_accu", i), accu, tbl[i].acc);
      check($sformatf("tbl%0d_carry", i), {7'd0, carry}, {7'd0, tbl[i].cy});
    end

    // Asynchronous reset in the EXEC cycle of ADD at 0x85
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_prog_addr", prog_addr, 8'h00);
    check("rst_accu", accu, 8'h00);
    check("rst_carry", {7'd0, carry}, 8'h00);
    check("rst_halted", {7'd0, halted}, 8'h00);
    check("rst_alu_code", {5'd0, alu_code}, {5'd0, `ALU_ADD});
    check("rst_alu_b", alu_b, 8'h00);
    check("rst_alu_ci", {7'd0, alu_ci}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run = 1'b1;
    model_reset();
    #1;
    check("post_rst_fetch0", prog_addr, 8'h00);
    step_and_check("post_rst_i0");

    // run held low in FETCH
    run = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("stall%0d_pc", c), prog_addr, m_pc);
      check($sformatf("stall%0d_accu", c), accu, m_a);
    end

    // run dropped during DECODE: instruction still completes
    run = 1'b1;
    ref_step();
    @(posedge clk);
    #1;
    run = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("toggle_pc", prog_addr, m_pc);
    check("toggle_accu", accu, m_a);
    @(posedge clk);
    #1;
    check("toggle_stalled_pc", prog_addr, m_pc);

    // PC wrap and HLT
    rom[m_pc] = 12'hCFE;
    rom[8'hFE] = 12'h000;
    rom[8'hFF] = 12'h000;
    rom[8'h00] = 12'hF00;
    run = 1'b1;
    step_and_check("wrap_jmp");
    step_and_check("wrap_nop_fe");
    step_and_check("wrap_nop_ff");
    check("wrap_to_zero", prog_addr, 8'h00);
    ref_step();
    repeat (2) @(posedge clk);
    #1;
    check("hlt_exec_not_halted", {7'd0, halted}, 8'h00);
    @(posedge clk);
    #1;
    check("hlt_halted", {7'd0, halted}, 8'h01);
    check("hlt_pc", prog_addr, 8'h01);
    for (int c = 0; c < 20; c++) begin
      run = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      check($sformatf("halt%0d_pc", c), prog_addr, 8'h01);
      check($sformatf("halt%0d_halted", c), {7'd0, halted}, 8'h01);
    end

    // Random programs against the reference model
    for (int p = 0; p < 8; p++) begin
      for (int a = 0; a < 256; a++) begin
        op = ($urandom_range(0, 39) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        rom[a] = {op, 8'($urandom)};
      end
      do_reset();
      run = 1'b1;
      for (int i = 0; i < 60 && !m_h; i++) begin
        step_and_check($sformatf("rnd%0d_%0d", p, i));
        if (!m_h && $urandom_range(0, 3) == 0) begin
          run = 1'b0;
          k = $urandom_range(1, 4);
          repeat (k) @(posedge clk);
          #1;
          check($sformatf("rnd%0d_%0d_stall", p, i), prog_addr, m_pc);
          run = 1'b1;
        end
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
